// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO responder: word-select bits,
// UART status bit positions and the serializer state encoding.
package io_pkg;

    localparam int unsigned IO_LEDS_BIT      = 0;
    localparam int unsigned IO_UART_DAT_BIT  = 1;
    localparam int unsigned IO_UART_CTRL_BIT = 2;

    localparam int unsigned IO_TX_ACTIVE_BIT = 8;
    localparam int unsigned IO_BUSY_BIT      = 9;
    localparam int unsigned IO_OVERFLOW_BIT  = 10;

    localparam int unsigned SER_STATE_W = 2;
    localparam logic [SER_STATE_W-1:0] SER_IDLE  = 2'd0;
    localparam logic [SER_STATE_W-1:0] SER_START = 2'd1;
    localparam logic [SER_STATE_W-1:0] SER_DATA  = 2'd2;
    localparam logic [SER_STATE_W-1:0] SER_STOP  = 2'd3;

    // Assemble the UART_CTRL read word from its three status flags.
    function automatic logic [31:0] io_status_word(input logic active,
                                                   input logic busy,
                                                   input logic overflow);
        logic [31:0] w;
        w = '0;
        w[IO_TX_ACTIVE_BIT] = active;
        w[IO_BUSY_BIT]      = busy;
        w[IO_OVERFLOW_BIT]  = overflow;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit serializer: pops a byte from the queue and shifts it out
// LSB first, each bit DIV cycles long, with back-to-back frames from STOP.
module uart_tx_serializer
    import io_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       pop,
    output logic       active,
    output logic       txd
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

    logic [SER_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             sh_q, sh_d;
    logic                   txd_q, txd_d;
    logic                   cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign active   = (state_q != SER_IDLE);
    assign txd      = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            SER_IDLE: begin
                txd_d = 1'b1;
                if (valid) begin
                    pop     = 1'b1;
                    sh_d    = data;
                    state_d = SER_START;
                    cnt_d   = CNT_LOAD;
                    txd_d   = 1'b0;
                end
            end
            SER_START: begin
                if (cnt_zero) begin
                    state_d = SER_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SER_DATA: begin
                if (cnt_zero) begin
                    cnt_d = CNT_LOAD;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = SER_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SER_STOP: begin
                // A waiting byte starts its frame straight after the stop bit.
                if (cnt_zero) begin
                    if (valid) begin
                        pop     = 1'b1;
                        sh_d    = data;
                        state_d = SER_START;
                        cnt_d   = CNT_LOAD;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = SER_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED register plus UART transmit queue/status.
// Define IO_TXFIFO_EN for a 2^FIFO_AW-entry TX FIFO; otherwise a single holding register.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_AW     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [5:0]  LEDS,
    output logic        uart_txd
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;

    if (DIV < 2) begin : g_div_check
        $error("io_responder: CLK_FREQ_HZ/BAUD must be at least 2");
    end

    logic sel_leds, sel_dat, sel_ctrl;
    logic push_req, push_ok;
    logic q_pop, q_valid, q_full;
    logic [7:0] q_data;
    logic ser_active;
    logic [5:0] leds_q, leds_d;
    logic overflow_q, overflow_d;
    logic unused_ok;

    assign sel_leds = IO_mem_addr[2 + IO_LEDS_BIT];
    assign sel_dat  = IO_mem_addr[2 + IO_UART_DAT_BIT];
    assign sel_ctrl = IO_mem_addr[2 + IO_UART_CTRL_BIT];

    assign unused_ok = ^{IO_mem_addr[31:5], IO_mem_addr[1:0],
                         IO_mem_wdata[31:11], IO_mem_wdata[9:8]};

    // Fullness is judged after a same-cycle pop, so a pop frees room for this write.
    assign push_req = IO_mem_wr & sel_dat;
    assign push_ok  = push_req & (~q_full | q_pop);

`ifdef IO_TXFIFO_EN
    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned QCNT_W = FIFO_AW + 1;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [QCNT_W-1:0]  count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + FIFO_AW'(1);
        if (q_pop)   rptr_d = rptr_q + FIFO_AW'(1);
        case ({push_ok, q_pop})
            2'b10:   count_d = count_q + QCNT_W'(1);
            2'b01:   count_d = count_q - QCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= IO_mem_wdata[7:0];
    end

    assign q_valid = (count_q != '0);
    assign q_full  = (count_q == QCNT_W'(DEPTH));
    assign q_data  = mem_q[rptr_q];
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       unused_cfg;

    assign unused_cfg = (FIFO_AW == 0);

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (q_pop) hold_valid_d = 1'b0;
        if (push_ok) begin
            hold_valid_d = 1'b1;
            hold_data_d  = IO_mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign q_valid = hold_valid_q;
    assign q_full  = hold_valid_q;
    assign q_data  = hold_data_q;
`endif

    uart_tx_serializer #(
        .DIV(DIV)
    ) u_ser (
        .clk    (clk),
        .resetn (resetn),
        .data   (q_data),
        .valid  (q_valid),
        .pop    (q_pop),
        .active (ser_active),
        .txd    (uart_txd)
    );

    // A dropped byte sets overflow even if the same write also clears it.
    always_comb begin
        leds_d     = leds_q;
        overflow_d = overflow_q;
        if (IO_mem_wr & sel_leds) leds_d = IO_mem_wdata[5:0];
        if (IO_mem_wr & sel_ctrl & IO_mem_wdata[IO_OVERFLOW_BIT]) overflow_d = 1'b0;
        if (push_req & q_full & ~q_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            leds_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            leds_q     <= leds_d;
            overflow_q <= overflow_d;
        end
    end

    assign LEDS = leds_q;

    always_comb begin
        IO_mem_rdata = '0;
        if (sel_leds) IO_mem_rdata = IO_mem_rdata | {26'd0, leds_q};
        if (sel_ctrl) IO_mem_rdata = IO_mem_rdata
                                   | io_status_word(q_valid | ser_active, q_full, overflow_q);
    end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed and random bus traffic checked against a
// bit-stream level model of the LED register, TX queue and UART line.
module tb_io_responder;

    localparam int unsigned DIV = 4;
`ifdef IO_TXFIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;
    logic [5:0]  LEDS;
    logic        uart_txd;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         line[$];
    logic [5:0] m_leds;
    logic       m_ovf;

    io_responder #(
        .CLK_FREQ_HZ(40),
        .BAUD       (10),
        .FIFO_AW    (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .IO_mem_addr  (IO_mem_addr),
        .IO_mem_wdata (IO_mem_wdata),
        .IO_mem_wr    (IO_mem_wr),
        .IO_mem_rdata (IO_mem_rdata),
        .LEDS         (LEDS),
        .uart_txd     (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit m_txd();
        return (line.size() > 0) ? line[0] : 1'b1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] rsel);
        logic [31:0] r;
        r = '0;
        if (rsel[0]) r[5:0] = m_leds;
        if (rsel[2]) begin
            r[8]  = (line.size() > 0) || (mq.size() > 0);
            r[9]  = (mq.size() == DEPTH);
            r[10] = m_ovf;
        end
        return r;
    endfunction

    // One clock: drive a bus cycle, advance the model, then sample away from the edge.
    task automatic step(input logic rst_n, input logic wr, input logic [2:0] wsel,
                        input logic [31:0] wd, input logic [2:0] rsel);
        logic [7:0] b;
        resetn       = rst_n;
        IO_mem_wr    = wr;
        IO_mem_addr  = {16'h0040, 11'd0, wsel, 2'b00};
        IO_mem_wdata = wd;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            line.delete();
            m_leds = '0;
            m_ovf  = 1'b0;
        end else begin
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && mq.size() > 0) begin
                b = mq.pop_front();
                for (int k = 0; k < 10; k++) begin
                    bit v;
                    v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    repeat (DIV) line.push_back(v);
                end
            end
            if (wr) begin
                if (wsel[0]) m_leds = wd[5:0];
                if (wsel[2] && wd[10]) m_ovf = 1'b0;
                if (wsel[1]) begin
                    if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
                    else m_ovf = 1'b1;
                end
            end
        end
        #1;
        IO_mem_wr    = 1'b0;
        IO_mem_addr  = {16'h0040, 11'd0, rsel, 2'b00};
        IO_mem_wdata = $urandom;
        #1;
        chk("txd",   {31'd0, uart_txd}, {31'd0, m_txd()});
        chk("leds",  {26'd0, LEDS},     {26'd0, m_leds});
        chk("rdata", IO_mem_rdata,      m_rdata(rsel));
    endtask

    initial begin
        logic [7:0]  b2b [5];
        logic [2:0]  wsel;
        logic [31:0] wd;
        resetn       = 1'b0;
        IO_mem_wr    = 1'b0;
        IO_mem_addr  = '0;
        IO_mem_wdata = '0;
        m_leds       = '0;
        m_ovf        = 1'b0;

        repeat (3) step(1'b0, 1'b0, 3'b000, 32'd0, 3'b100);
        chk("reset_ctrl", IO_mem_rdata, 32'h0);
        chk("reset_txd", {31'd0, uart_txd}, 32'd1);

        step(1'b1, 1'b1, 3'b001, 32'h0000_003F, 3'b001);
        chk("led_read", IO_mem_rdata, 32'h0000_003F);
        step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);

        step(1'b1, 1'b1, 3'b010, 32'h0000_00A5, 3'b100);
        repeat (45) step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);
        chk("single_idle_ctrl", IO_mem_rdata, 32'h0);

        b2b = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b010, {24'd0, b2b[i]}, 3'b100);
        repeat (220) step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);
        step(1'b1, 1'b1, 3'b100, 32'h0000_0400, 3'b100);
        chk("b2b_idle_ctrl", IO_mem_rdata, 32'h0);

        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'b010, $urandom, 3'b100);
        chk("overflow_ctrl", IO_mem_rdata, 32'h0000_0700);
        step(1'b1, 1'b1, 3'b100, 32'h0000_0400, 3'b100);
        chk("overflow_clear", IO_mem_rdata, 32'h0000_0300);
        repeat (260) step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);

        step(1'b1, 1'b1, 3'b010, 32'h0000_005A, 3'b100);
        step(1'b1, 1'b1, 3'b010, 32'h0000_00C3, 3'b100);
        repeat (17) step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);
        step(1'b0, 1'b0, 3'b000, 32'd0, 3'b100);
        chk("midframe_reset_txd", {31'd0, uart_txd}, 32'd1);
        chk("midframe_reset_ctrl", IO_mem_rdata, 32'h0);
        repeat (50) step(1'b1, 1'b0, 3'b000, 32'd0, 3'b100);
        chk("post_reset_ctrl", IO_mem_rdata, 32'h0);

        for (int i = 0; i < 400; i++) begin
            wsel = 3'($urandom_range(1, 7));
            wd   = $urandom;
            if (wsel[1] && wsel[2]) wd[10] = 1'b0;
            step(1'b1, 1'($urandom_range(0, 1)), wsel, wd, 3'($urandom_range(0, 7)));
        end
        repeat (60) step(1'b1, 1'b0, 3'b000, 32'd0, 3'($urandom_range(0, 7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
